// File: rtl/rec_tq_perm_pipe.sv
// rec_tq_perm_pipe
//   Registered, handshaked lane-reorder stage for the rec_tq row/column
//   transform datapath. Each beat carries one TU row of up to LANES
//   coefficients. i_dir=0 applies the even/odd butterfly-decimation order
//   ahead of the partial-butterfly stage. i_dir=1 applies its exact inverse
//   to reassemble stage outputs. A per-TU row counter latches the transform
//   size on row 0 and flags the last row of the TU.
//
// Handshake (valid/ready): a beat moves across an interface on a rising
//   edge where valid and ready are both high. The upstream side accepts
//   when i_valid & o_ready, with o_ready = ~o_valid | i_ready. The output
//   register holds exactly one beat. Once o_valid is raised, o_data,
//   o_transize and o_last stay unchanged until i_ready is seen high, or
//   until i_clear drops the beat.
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   i_clear      synchronous TU abort: row counter to 0, output beat dropped
//   i_valid      input beat valid             o_ready   stage can accept
//   i_transize   0:4x4 1:8x8 2:16x16 3:32x32, sampled on row 0 only
//   i_dir        0 = decimate, 1 = reassemble (sampled per beat)
//   i_data       lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_valid      output beat valid            i_ready   downstream accepts
//   o_data       reordered lanes
//   o_transize   size latched for the TU this beat belongs to
//   o_last       beat is row N-1 of its TU
module rec_tq_perm_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 32   // 8, 16 or 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_clear,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [1:0]                  i_transize,
  input  logic                        i_dir,
  input  logic [LANES*DATA_WIDTH-1:0] i_data,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [LANES*DATA_WIDTH-1:0] o_data,
  output logic [1:0]                  o_transize,
  output logic                        o_last
);

  localparam int W = LANES * DATA_WIDTH;
  // Largest size whose N fits in one beat: log2(LANES)-2.
  localparam logic [1:0] S_MAX = (LANES == 8) ? 2'd1 : (LANES == 16) ? 2'd2 : 2'd3;

  // Source lane, within an N-lane group, that feeds decimated output j.
  // The upper half of each level takes the odd inputs in ascending order.
  // The lower half recurses on the even inputs, which doubles the stride.
  function automatic int dec_src(input int j, input int n);
    int nn;
    int stride;
    int res;
    logic done;
    nn     = n;
    stride = 1;
    res    = 0;
    done   = 1'b0;
    for (int l = 0; l < 3; l++) begin
      if (!done && nn > 4) begin
        if (j >= nn / 2) begin
          res  = stride * (2 * (j - nn / 2) + 1);
          done = 1'b1;
        end else begin
          stride = stride * 2;
          nn     = nn / 2;
        end
      end
    end
    if (!done) res = stride * j;
    return res;
  endfunction

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic [1:0]   tsize_q, tsize_d;
  logic         last_q, last_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [1:0]   size_q, size_d;

  logic         accept;
  logic [1:0]   ts_sat;
  logic [1:0]   eff_s;
  logic [5:0]   n_eff;
  logic         row_last;
  logic [W-1:0] perm_s [4];
  logic [W-1:0] perm;

  assign o_ready = ~valid_q | i_ready;
  assign accept  = i_valid & o_ready;

  // Row 0 takes the incoming size. Later rows reuse the size latched for the TU.
  assign ts_sat   = (i_transize > S_MAX) ? S_MAX : i_transize;
  assign eff_s    = (cnt_q == 5'd0) ? ts_sat : size_q;
  assign n_eff    = 6'd4 << eff_s;
  assign row_last = ({1'b0, cnt_q} == (n_eff - 6'd1));

  // One fixed routing per size. Each size applies the same map to every
  // N-lane group. Sizes that do not fit the beat stay at zero and are never
  // selected, because the size is saturated.
  always_comb begin
    for (int s = 0; s < 4; s++) begin
      perm_s[s] = '0;
      if ((4 << s) <= LANES) begin
        for (int k = 0; k < LANES; k++) begin
          int n;
          int src;
          n   = 4 << s;
          src = (k / n) * n + dec_src(k % n, n);
          if (!i_dir)
            perm_s[s][k*DATA_WIDTH +: DATA_WIDTH] = i_data[src*DATA_WIDTH +: DATA_WIDTH];
          else
            perm_s[s][src*DATA_WIDTH +: DATA_WIDTH] = i_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign perm = perm_s[eff_s];

  // Next state. Clear outranks accept and output hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    tsize_d = tsize_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    if (i_clear) begin
      valid_d = 1'b0;
      cnt_d   = 5'd0;
    end else if (accept) begin
      valid_d = 1'b1;
      data_d  = perm;
      tsize_d = eff_s;
      last_d  = row_last;
      cnt_d   = row_last ? 5'd0 : cnt_q + 5'd1;
      if (cnt_q == 5'd0) size_d = ts_sat;
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      tsize_q <= 2'd0;
      last_q  <= 1'b0;
      cnt_q   <= 5'd0;
      size_q  <= 2'd0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      tsize_q <= tsize_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_data     = data_q;
  assign o_transize = tsize_q;
  assign o_last     = last_q;

endmodule
